// File: rtl/rect_fill_writer.sv
// rect_fill_writer: fills clipped rectangles into a 640x480 3-bit framebuffer.
// Ports: cmd_* request (valid/ready), Waddr/Wdata paced by ready, busy, done.
module rect_fill_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk_100mhz_buf,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [2:0]  cmd_color,
  input  logic        ready,
  output logic [18:0] Waddr,
  output logic [2:0]  Wdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_DRAW, S_DONE
  } state_t;

  localparam logic [10:0] XLIM   = 11'(H_RES);
  localparam logic [9:0]  YLIM   = 10'(V_RES);
  localparam logic [18:0] STRIDE = 19'(H_RES);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, w_q, w_d;
  logic [8:0]  y_q, y_d, h_q, h_d;
  logic [2:0]  color_q, color_d;
  logic [10:0] x_end_q, x_end_d;
  logic [9:0]  y_end_q, y_end_d;
  logic [9:0]  cur_x_q, cur_x_d;
  logic [8:0]  cur_y_q, cur_y_d;
  logic [18:0] row_base_q, row_base_d;
  logic [18:0] waddr_q, waddr_d;
  logic [2:0]  wdata_q, wdata_d;

  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic [18:0] y_ext, setup_base;
  logic        empty, col_more, row_more;

  always_comb begin
    x_sum = {1'b0, x_q} + {1'b0, w_q};
    y_sum = {1'b0, y_q} + {1'b0, h_q};
    y_ext = {10'd0, y_q};
    // y*640 as y*512 + y*128
    setup_base = (y_ext << 9) + (y_ext << 7);
    empty = (w_q == '0) || (h_q == '0) ||
            ({1'b0, x_q} >= XLIM) ||
            ({1'b0, y_q} >= YLIM);
    col_more = ({1'b0, cur_x_q} + 11'd1) < x_end_q;
    row_more = ({1'b0, cur_y_q} + 10'd1) < y_end_q;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x_end_d = (x_sum > XLIM) ? XLIM : x_sum;
        y_end_d = (y_sum > YLIM) ? YLIM : y_sum;
        if (empty) begin
          state_d = S_DONE;
        end else begin
          cur_x_d    = x_q;
          cur_y_d    = y_q;
          row_base_d = setup_base;
          waddr_d    = setup_base + {9'd0, x_q};
          wdata_d    = color_q;
          state_d    = S_DRAW;
        end
      end
      S_DRAW: begin
        if (ready) begin
          if (col_more) begin
            cur_x_d = cur_x_q + 10'd1;
            waddr_d = waddr_q + 19'd1;
          end else if (row_more) begin
            row_base_d = row_base_q + STRIDE;
            cur_y_d    = cur_y_q + 9'd1;
            cur_x_d    = x_q;
            waddr_d    = row_base_q + STRIDE + {9'd0, x_q};
          end else begin
            // last pixel taken; address holds on it
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz_buf or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Waddr     = waddr_q;
  assign Wdata     = wdata_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb_rect_fill_writer: table vectors, corner sequences and random commands
// checked against a pixel-list model of the clipped rectangle.
module tb_rect_fill_writer;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [2:0]  cmd_color;
  logic        ready;
  logic [18:0] Waddr;
  logic [2:0]  Wdata;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int last_a = 0;
  int last_d = 0;

  rect_fill_writer #(.H_RES(H), .V_RES(V)) dut (
    .clk_100mhz_buf(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .ready(ready),
    .Waddr(Waddr),
    .Wdata(Wdata),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int w; int h; int c;
    int mode;
    int exp_n; int exp_first; int exp_last; int exp_edges;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // mode: 0 ready=1, 1 ready alternating 0/1, 2 random ready,
  //       3 ready=1 plus a command pulse during DRAW
  task automatic run_cmd(input int x, input int y, input int w,
                         input int h, input int c, input int mode,
                         output int n_got, output int edges,
                         output int fst, output int lst);
    int exp_a[$];
    int got_a[$];
    int got_d[$];
    int xe, ye, rdy_cnt, exp_edges, dcnt;
    bit seen, r;
    xe = (x + w > H) ? H : x + w;
    ye = (y + h > V) ? V : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_a.push_back(yy * H + xx);

    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w);
    cmd_h = 9'(h); cmd_color = 3'(c);
    cmd_valid = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x = 10'($urandom); cmd_y = 9'($urandom);
    cmd_w = 10'($urandom); cmd_h = 9'($urandom);
    cmd_color = 3'($urandom);
    @(posedge clk);
    edges = 0;
    rdy_cnt = 0;
    exp_edges = (exp_a.size() == 0) ? 0 : -1;
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      case (mode)
        1: r = ((edges + 1) % 2) == 0;
        2: r = 1'($urandom);
        default: r = 1'b1;
      endcase
      ready = r;
      if (mode == 3 && edges == 2) begin
        cmd_valid = 1'b1;
        cmd_x = 10'd0; cmd_y = 9'd0;
        cmd_w = 10'd20; cmd_h = 9'd20; cmd_color = 3'd7;
      end else begin
        cmd_valid = 1'b0;
      end
      if (r && busy) begin
        got_a.push_back(int'(Waddr));
        got_d.push_back(int'(Wdata));
        rdy_cnt++;
        if (rdy_cnt == exp_a.size()) exp_edges = edges + 1;
      end
      @(posedge clk);
      edges++;
    end
    cmd_valid = 1'b0;
    ready = 1'b1;
    chk("done_seen", int'(seen), 1);
    chk("pixel_count", got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("addr[%0d]", i), got_a[i], exp_a[i]);
      chk($sformatf("data[%0d]", i), got_d[i], c);
    end
    chk("done_latency", edges, exp_edges);
    if (exp_a.size() != 0) begin
      last_a = exp_a[exp_a.size() - 1];
      last_d = c;
    end
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("cmd_ready_back", int'(cmd_ready), 1);
    chk("busy_back", int'(busy), 0);
    chk("waddr_hold", int'(Waddr), last_a);
    chk("wdata_hold", int'(Wdata), last_d);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_extra_done", dcnt, 0);
    n_got = got_a.size();
    fst = (got_a.size() != 0) ? got_a[0] : -1;
    lst = (got_a.size() != 0) ? got_a[got_a.size() - 1] : -1;
  endtask

  initial begin
    vec_t vt[8];
    int n, e, f, l, dcnt;
    int rx, ry, rw, rh;

    vt[0] = '{10, 5, 3, 2, 3, 0, 6, 3210, 3852, 6};
    vt[1] = '{638, 479, 5, 3, 5, 0, 2, 307198, 307199, 2};
    vt[2] = '{10, 5, 3, 2, 3, 1, 6, 3210, 3852, 12};
    vt[3] = '{100, 100, 0, 4, 6, 0, 0, -1, -1, 0};
    vt[4] = '{700, 10, 5, 5, 2, 0, 0, -1, -1, 0};
    vt[5] = '{10, 5, 3, 2, 3, 3, 6, 3210, 3852, 6};
    vt[6] = '{630, 0, 20, 1, 7, 0, 10, 630, 639, 10};
    vt[7] = '{5, 480, 3, 3, 1, 0, 0, -1, -1, 0};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waddr", int'(Waddr), 0);
    chk("rst_wdata", int'(Wdata), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].c,
              vt[i].mode, n, e, f, l);
      chk($sformatf("vec%0d_n", i), n, vt[i].exp_n);
      chk($sformatf("vec%0d_edges", i), e, vt[i].exp_edges);
      if (vt[i].exp_n != 0) begin
        chk($sformatf("vec%0d_first", i), f, vt[i].exp_first);
        chk($sformatf("vec%0d_last", i), l, vt[i].exp_last);
      end
    end

    // reset in the middle of a fill
    @(negedge clk);
    cmd_x = 10'd0; cmd_y = 9'd2; cmd_w = 10'd20;
    cmd_h = 9'd5; cmd_color = 3'd4;
    cmd_valid = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_waddr", int'(Waddr), 0);
    chk("mid_rst_wdata", int'(Wdata), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    chk("post_rst_waddr", int'(Waddr), 0);
    last_a = 0;
    last_d = 0;

    // random commands with random pacing
    for (int i = 0; i < 30; i++) begin
      rx = ($urandom % 3 == 0) ? 630 + $urandom_range(0, 15)
                               : $urandom_range(0, 700);
      ry = ($urandom % 3 == 0) ? 474 + $urandom_range(0, 10)
                               : $urandom_range(0, 490);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 6);
      run_cmd(rx, ry, rw, rh, $urandom_range(0, 7), 2, n, e, f, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
